cu_pipe: RTL



---
 rtl/cu_pkg.sv | 92 +++++++++
 rtl/cu_decode.sv | 48 ++++
 rtl/cu_pipe.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cu_pkg: opcodes, control-bundle layout and FSM states for cu_pipe |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package cu_pkg;

   localparam int CU_OPCODE_W  = 6;
   localparam int CU_ALU_SEL_W = 4;
   localparam int CU_WB_SEL_W  = 3;

   typedef logic [CU_OPCODE_W-1:0] opcode_t;

   localparam opcode_t OP_NOP   = 6'h00;
   localparam opcode_t OP_ADD   = 6'h01;
   localparam opcode_t OP_SUB   = 6'h02;
   localparam opcode_t OP_OR    = 6'h03;
   localparam opcode_t OP_AND   = 6'h04;
   localparam opcode_t OP_XOR   = 6'h05;
   localparam opcode_t OP_NOR   = 6'h06;
   localparam opcode_t OP_NAND  = 6'h07;
   localparam opcode_t OP_XNOR  = 6'h08;
   localparam opcode_t OP_INV   = 6'h09;
   localparam opcode_t OP_BSHL  = 6'h0A;
   localparam opcode_t OP_BSHR  = 6'h0B;
   localparam opcode_t OP_SBSHL = 6'h0C;
   localparam opcode_t OP_SBSHR = 6'h0D;
   localparam opcode_t OP_LDIM  = 6'h0E;
   localparam opcode_t OP_LDIMW = 6'h0F;
   localparam opcode_t OP_HALT  = 6'h3F;

   localparam logic [CU_ALU_SEL_W-1:0] ALU_SEL_ADD   = 4'h0;
   localparam logic [CU_ALU_SEL_W-1:0] ALU_SEL_SUB   = 4'h1;
   localparam logic [CU_ALU_SEL_W-1:0] ALU_SEL_OR    = 4'h2;
   localparam logic [CU_ALU_SEL_W-1:0] ALU_SEL_AND   = 4'h3;
   localparam logic [CU_ALU_SEL_W-1:0] ALU_SEL_XOR   = 4'h4;
   localparam logic [CU_ALU_SEL_W-1:0] ALU_SEL_NOR   = 4'h5;
   localparam logic [CU_ALU_SEL_W-1:0] ALU_SEL_NAND  = 4'h6;
   localparam logic [CU_ALU_SEL_W-1:0] ALU_SEL_XNOR  = 4'h7;
   localparam logic [CU_ALU_SEL_W-1:0] ALU_SEL_BSHR  = 4'h8;
   localparam logic [CU_ALU_SEL_W-1:0] ALU_SEL_BSHL  = 4'h9;
   localparam logic [CU_ALU_SEL_W-1:0] ALU_SEL_SBSHL = 4'hA;
   localparam logic [CU_ALU_SEL_W-1:0] ALU_SEL_SBSHR = 4'hB;
   localparam logic [CU_ALU_SEL_W-1:0] ALU_SEL_INV   = 4'hC;

   localparam logic [CU_WB_SEL_W-1:0] WB_SEL_ALU  = 3'b000;
   localparam logic [CU_WB_SEL_W-1:0] WB_SEL_SIMM = 3'b001;
   localparam logic [CU_WB_SEL_W-1:0] WB_SEL_WIMM = 3'b010;

   localparam logic [1:0] IT_NONE = 2'b00;
   localparam logic [1:0] IT_ALU  = 2'b01;
   localparam logic [1:0] IT_LDI  = 2'b10;

   typedef struct packed {
      logic [1:0]              inst_type;
      logic [CU_ALU_SEL_W-1:0] alu_sel;
      logic [CU_WB_SEL_W-1:0]  wb_sel;
      logic                    alu_c_in;
      logic                    alu_enable;
      logic                    reg_read_a;
      logic                    reg_read_b;
      logic                    reg_write;
      logic                    reg_reset;
   } ctrl_t;

   typedef enum logic [1:0] {
      S_DECODE = 2'd0,
      S_IMM    = 2'd1,
      S_HALT   = 2'd2
   } state_t;

   function automatic logic [CU_ALU_SEL_W-1:0] alu_sel_of(input opcode_t op);
      case (op)
         OP_ADD:   alu_sel_of = ALU_SEL_ADD;
         OP_SUB:   alu_sel_of = ALU_SEL_SUB;
         OP_OR:    alu_sel_of = ALU_SEL_OR;
         OP_AND:   alu_sel_of = ALU_SEL_AND;
         OP_XOR:   alu_sel_of = ALU_SEL_XOR;
         OP_NOR:   alu_sel_of = ALU_SEL_NOR;
         OP_NAND:  alu_sel_of = ALU_SEL_NAND;
         OP_XNOR:  alu_sel_of = ALU_SEL_XNOR;
         OP_INV:   alu_sel_of = ALU_SEL_INV;
         OP_BSHL:  alu_sel_of = ALU_SEL_BSHL;
         OP_BSHR:  alu_sel_of = ALU_SEL_BSHR;
         OP_SBSHL: alu_sel_of = ALU_SEL_SBSHL;
         OP_SBSHR: alu_sel_of = ALU_SEL_SBSHR;
         default:  alu_sel_of = ALU_SEL_ADD;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/cu_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cu_decode: combinational opcode -> control bundle and class flags |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module cu_decode
   import cu_pkg::*;
(
   input  logic [CU_OPCODE_W-1:0] i_opcode,
   output ctrl_t                  o_ctrl,
   output logic                   o_is_nop,
   output logic                   o_is_ldimw,
   output logic                   o_is_halt,
   output logic                   o_is_illegal
);

   always_comb begin
      o_ctrl       = '0;
      o_is_nop     = 1'b0;
      o_is_ldimw   = 1'b0;
      o_is_halt    = 1'b0;
      o_is_illegal = 1'b0;
      // The ALU opcodes occupy one contiguous block.
      if (i_opcode >= OP_ADD && i_opcode <= OP_SBSHR) begin
         o_ctrl.inst_type  = IT_ALU;
         o_ctrl.alu_sel    = alu_sel_of(i_opcode);
         o_ctrl.wb_sel     = WB_SEL_ALU;
         o_ctrl.alu_enable = 1'b1;
         o_ctrl.reg_read_a = 1'b1;
         o_ctrl.reg_read_b = (i_opcode != OP_INV);
         o_ctrl.reg_write  = 1'b1;
      end else begin
         case (i_opcode)
            OP_NOP:   o_is_nop   = 1'b1;
            OP_LDIMW: o_is_ldimw = 1'b1;
            OP_HALT:  o_is_halt  = 1'b1;
            OP_LDIM: begin
               o_ctrl.inst_type = IT_LDI;
               o_ctrl.wb_sel    = WB_SEL_SIMM;
               o_ctrl.reg_write = 1'b1;
            end
            default:  o_is_illegal = 1'b1;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/cu_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cu_pipe: registered, handshaked control unit with LDIMW/HALT FSM  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module cu_pipe
   import cu_pkg::*;
#(
   parameter int WORD_W    = 16,
   parameter int OPCODE_W  = 6,
   parameter int ALU_SEL_W = 4,
   parameter int WB_SEL_W  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_W-1:0]    in_word,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           inst_type,
   output logic [ALU_SEL_W-1:0] alu_sel,
   output logic [WB_SEL_W-1:0]  wb_sel,
   output logic                 alu_c_in,
   output logic                 alu_enable,
   output logic                 reg_read_a,
   output logic                 reg_read_b,
   output logic                 reg_write,
   output logic                 reg_reset,
   output logic [WORD_W-1:0]    out_imm,
   output logic                 illegal,
   output logic                 halted
);

   localparam int IMM_W = WORD_W - OPCODE_W;

   state_t              r_state;
   ctrl_t               r_ctrl;
   logic [WORD_W-1:0]   r_imm;
   logic                r_out_valid;
   logic                r_illegal;
   logic                r_halted;

   ctrl_t               w_dec;
   logic                w_is_nop;
   logic                w_is_ldimw;
   logic                w_is_halt;
   logic                w_is_illegal;
   logic                w_accept;
   logic [CU_OPCODE_W-1:0] w_opcode;
   logic [WORD_W-1:0]   w_short_imm;
   ctrl_t               w_wide_ctrl;

   assign w_opcode    = CU_OPCODE_W'(in_word[WORD_W-1 -: OPCODE_W]);
   assign w_short_imm = {{OPCODE_W{1'b0}}, in_word[IMM_W-1:0]};
   assign in_ready    = (r_state != S_HALT) && (!r_out_valid || out_ready);
   assign w_accept    = in_valid && in_ready;

   always_comb begin
      w_wide_ctrl           = '0;
      w_wide_ctrl.inst_type = IT_LDI;
      w_wide_ctrl.wb_sel    = WB_SEL_WIMM;
      w_wide_ctrl.reg_write = 1'b1;
   end

   cu_decode u_decode (
      .i_opcode     (w_opcode),
      .o_ctrl       (w_dec),
      .o_is_nop     (w_is_nop),
      .o_is_ldimw   (w_is_ldimw),
      .o_is_halt    (w_is_halt),
      .o_is_illegal (w_is_illegal)
   );

   // Backpressure freezes everything because in_ready drops, so no accept occurs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_DECODE;
         r_ctrl      <= '0;
         r_imm       <= '0;
         r_out_valid <= 1'b0;
         r_illegal   <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept) begin
            case (r_state)
               S_DECODE: begin
                  if (w_is_ldimw) begin
                     r_state <= S_IMM;
                  end else if (w_is_halt) begin
                     r_halted <= 1'b1;
                     r_state  <= S_HALT;
                  end else if (w_is_illegal) begin
                     r_illegal <= 1'b1;
                  end else if (!w_is_nop) begin
                     r_ctrl      <= w_dec;
                     r_imm       <= (w_dec.wb_sel == WB_SEL_SIMM) ? w_short_imm : '0;
                     r_out_valid <= 1'b1;
                  end
               end
               S_IMM: begin
                  r_ctrl      <= w_wide_ctrl;
                  r_imm       <= in_word;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DECODE;
               end
               default: r_state <= r_state;
            endcase
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign inst_type  = r_ctrl.inst_type;
   assign alu_sel    = ALU_SEL_W'(r_ctrl.alu_sel);
   assign wb_sel     = WB_SEL_W'(r_ctrl.wb_sel);
   assign alu_c_in   = r_ctrl.alu_c_in;
   assign alu_enable = r_ctrl.alu_enable;
   assign reg_read_a = r_ctrl.reg_read_a;
   assign reg_read_b = r_ctrl.reg_read_b;
   assign reg_write  = r_ctrl.reg_write;
   assign reg_reset  = r_ctrl.reg_reset;
   assign out_imm    = r_imm;
   assign illegal    = r_illegal;
   assign halted     = r_halted;

endmodule
`default_nettype wire
